countdown_display: RTL and testbench

- Consumer end of the countdown timer's `countdown` output; drives the board's 4-digit multiplexed seven-segment display.
- Captures a binary count on a valid strobe and converts it to BCD with a sequential double-dabble engine.
- Time-multiplexes the digits with leading-zero blanking.
- Sits between the countdown timer and the FPGA display pins.

---
 rtl/countdown_display.sv | 225 ++++++++++++++++++++++
 tb/tb_countdown_display.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_display.sv
// Captures a binary count, converts it to BCD with a serial double-dabble engine and scans it
// onto a 4-digit multiplexed seven-segment display. Define ZERO_BLINK_EN to blink a zero value.
module countdown_display #(
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 250
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] count_in,
  input  logic             count_valid,
  input  logic             blank,
  output logic [3:0]       anode_n,
  output logic [6:0]       seg_n,
  output logic             dp_n,
  output logic             busy,
  output logic             overflow
);

  localparam int unsigned CntBits = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam int unsigned RefW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StConvert, StCommit} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bin_q, bin_d;
  logic [13:0]        value_q, value_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [CntBits-1:0] bit_q, bit_d;
  logic [CNT_W-1:0]   pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic [15:0]        digits_q, digits_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        adj;
  logic               unused_adj_msb;

  // Add 3 to every nibble >= 5 so the following shift yields a valid BCD digit.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end
  assign unused_adj_msb = adj[15];

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    value_d    = value_q;
    bcd_d      = bcd_q;
    bit_d      = bit_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    unique case (state_q)
      StIdle: begin
        if (count_valid) begin
          bin_d   = count_in;
          value_d = 14'(count_in);
          bcd_d   = '0;
          bit_d   = '0;
          state_d = StConvert;
        end
      end
      StConvert: begin
        bcd_d = {adj[14:0], bin_q[CNT_W-1]};
        bin_d = bin_q << 1;
        bit_d = bit_q + 1'b1;
        if (bit_q == CntBits'(CNT_W - 1)) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        digits_d   = bcd_q;
        overflow_d = (value_q > 14'd9999);
        if (pend_vld_q) begin
          bin_d      = pend_q;
          value_d    = 14'(pend_q);
          bcd_d      = '0;
          bit_d      = '0;
          pend_vld_d = 1'b0;
          state_d    = StConvert;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A strobe landing on the commit cycle refills the slot the commit is draining.
    if (count_valid && (state_q != StIdle)) begin
      pend_d     = count_in;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      value_q    <= '0;
      bcd_q      <= '0;
      bit_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      value_q    <= value_d;
      bcd_q      <= bcd_d;
      bit_q      <= bit_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign overflow = overflow_q;
  assign dp_n     = 1'b1;

  logic [RefW-1:0] ref_q;
  logic [1:0]      idx_q;
  logic            ref_wrap;

  assign ref_wrap = (ref_q == RefW'(REFRESH_DIV - 1));

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      ref_q <= '0;
      idx_q <= '0;
    end else if (ref_wrap) begin
      ref_q <= '0;
      idx_q <= idx_q + 2'd1;
    end else begin
      ref_q <= ref_q + 1'b1;
    end
  end

  logic       blink_off;

`ifdef ZERO_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_phase_q;
  logic              zero_shown;

  assign zero_shown = (digits_q == 16'd0) && !overflow_q;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (!zero_shown) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (ref_wrap) begin
      if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  assign blink_off = blink_phase_q;
`else
  logic unused_blink_div;
  assign unused_blink_div = BLINK_DIV[0];
  assign blink_off        = 1'b0;
`endif

  logic [3:0] nz;
  logic [3:0] vis;
  logic [3:0] cur_digit;
  logic       show;
  logic [3:0] anode_d;
  logic [6:0] seg_d;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      nz[i] = (digits_q[4*i +: 4] != 4'd0);
    end
    // A digit lights only if it or a more significant digit is nonzero; digit 0 always lights.
    vis       = {nz[3], |nz[3:2], |nz[3:1], 1'b1};
    cur_digit = digits_q[{idx_q, 2'b00} +: 4];
    show      = (overflow_q || vis[idx_q]) && !blank && !blink_off;
    anode_d   = show ? ~(4'b0001 << idx_q) : 4'b1111;
    if (overflow_q) begin
      seg_d = 7'b0111111;
    end else begin
      unique case (cur_digit)
        4'd0:    seg_d = 7'b1000000;
        4'd1:    seg_d = 7'b1111001;
        4'd2:    seg_d = 7'b0100100;
        4'd3:    seg_d = 7'b0110000;
        4'd4:    seg_d = 7'b0011001;
        4'd5:    seg_d = 7'b0010010;
        4'd6:    seg_d = 7'b0000010;
        4'd7:    seg_d = 7'b1111000;
        4'd8:    seg_d = 7'b0000000;
        4'd9:    seg_d = 7'b0010000;
        default: seg_d = 7'b0111111;
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      anode_n <= 4'b1110;
      seg_n   <= 7'b1000000;
    end else begin
      anode_n <= anode_d;
      seg_n   <= seg_d;
    end
  end

endmodule

// File: tb/tb_countdown_display.sv
// Scoreboard bench for countdown_display: commits (busy falling) are checked against queued
// expected display scans; one instance with CNT_W=5 and one with CNT_W=14.
module tb_countdown_display;

  localparam int REF = 4;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SD = 7'b0111111;
  localparam logic [6:0] SX = 7'b1111111;

  typedef struct packed {
    logic [3:0][3:0] an;
    logic [3:0][6:0] sg;
    logic            ovf;
  } exp_t;

  logic        clock_in = 1'b0;
  logic        reset_n  = 1'b0;
  logic        blank    = 1'b0;
  logic        sel      = 1'b0;
  logic [4:0]  cnt5     = '0;
  logic [13:0] cnt14    = '0;
  logic        valid5   = 1'b0;
  logic        valid14  = 1'b0;

  logic [3:0] an5, an14, an_m;
  logic [6:0] sg5, sg14, sg_m;
  logic       dp5, dp14, busy5, busy14, busy_m, ovf5, ovf14, ovf_m;

  int   errors = 0;
  int   checks = 0;
  int   k;
  exp_t sb_q[$];
  logic mon_active = 1'b0;
  logic watch9     = 1'b0;
  logic seen9;

  always #5 clock_in = ~clock_in;

  countdown_display #(.CNT_W(5), .REFRESH_DIV(REF), .BLINK_DIV(2)) dut5 (
    .clock_in(clock_in), .reset_n(reset_n), .count_in(cnt5), .count_valid(valid5),
    .blank(blank), .anode_n(an5), .seg_n(sg5), .dp_n(dp5), .busy(busy5), .overflow(ovf5)
  );

  countdown_display #(.CNT_W(14), .REFRESH_DIV(REF), .BLINK_DIV(2)) dut14 (
    .clock_in(clock_in), .reset_n(reset_n), .count_in(cnt14), .count_valid(valid14),
    .blank(blank), .anode_n(an14), .seg_n(sg14), .dp_n(dp14), .busy(busy14), .overflow(ovf14)
  );

  assign an_m   = sel ? an14 : an5;
  assign sg_m   = sel ? sg14 : sg5;
  assign busy_m = sel ? busy14 : busy5;
  assign ovf_m  = sel ? ovf14 : ovf5;

  // Bench model of the scan position: rising edges since reset release.
  always @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) k <= 0;
    else          k <= k + 1;
  end

  always @(negedge clock_in) begin
    if (!watch9)                                 seen9 <= 1'b0;
    else if (an_m != 4'b1111 && sg_m == S9)      seen9 <= 1'b1;
  end

  function automatic int slot_of(input int kk);
    return (kk == 0) ? 0 : ((kk - 1) / REF) % 4;
  endfunction

  function automatic exp_t mk(input logic [15:0] an, input logic [27:0] sg, input logic ovf);
    exp_t e;
    e.an  = an;
    e.sg  = sg;
    e.ovf = ovf;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0b required %0b", name, act, req);
    end
  endtask

  // Samples four full scan rounds and checks every slot's anode (and segments if lit).
  task automatic scan_display(input exp_t e, input string tag);
    logic [3:0] bad = '0;
    logic [3:0] bad_an [4];
    logic [6:0] bad_sg [4];
    @(negedge clock_in);
    for (int c = 0; c < 4 * REF * 4; c++) begin
      int s = slot_of(k);
      if (!bad[s] && (an_m !== e.an[s] || (e.an[s] != 4'b1111 && sg_m !== e.sg[s]))) begin
        bad[s]    = 1'b1;
        bad_an[s] = an_m;
        bad_sg[s] = sg_m;
      end
      @(negedge clock_in);
    end
    for (int s = 0; s < 4; s++) begin
      checks++;
      if (bad[s]) begin
        errors++;
        $display("FAIL %s slot%0d: got anode_n=%b seg_n=%b required anode_n=%b seg_n=%b",
                 tag, s, bad_an[s], bad_sg[s], e.an[s], e.sg[s]);
      end
    end
  endtask

  // Monitor: a falling busy is a commit; pop and compare against the queued expectation.
  initial begin
    logic busy_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clock_in);
      if (!reset_n) begin
        busy_prev = 1'b0;
      end else begin
        if (busy_prev && !busy_m) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_commit: got commit required none");
          end else begin
            mon_active = 1'b1;
            e = sb_q.pop_front();
            check("overflow", 32'(ovf_m), 32'(e.ovf));
            scan_display(e, "commit");
            mon_active = 1'b0;
          end
        end
        busy_prev = busy_m;
      end
    end
  end

  task automatic strobe(input int v);
    @(negedge clock_in);
    if (sel) begin
      cnt14 = 14'(v); valid14 = 1'b1;
    end else begin
      cnt5  = 5'(v);  valid5  = 1'b1;
    end
    @(negedge clock_in);
    valid5  = 1'b0;
    valid14 = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy_m) break;
      n++;
      @(negedge clock_in);
    end
  endtask

  task automatic wait_sb();
    for (int c = 0; c < 400; c++) begin
      @(posedge clock_in);
      if (sb_q.size() == 0 && !mon_active) return;
    end
    checks++;
    errors++;
    $display("FAIL sb_timeout: got %0d pending entries required 0", sb_q.size());
    sb_q.delete();
  endtask

  initial begin
    exp_t e0, e27, e12, eovf, e42;
    int   n;
    e0   = mk({4'hf, 4'hf, 4'hf, 4'he}, {SX, SX, SX, S0}, 1'b0);
    e27  = mk({4'hf, 4'hf, 4'hd, 4'he}, {SX, SX, S2, S7}, 1'b0);
    e12  = mk({4'hf, 4'hf, 4'hd, 4'he}, {SX, SX, S1, S2}, 1'b0);
    eovf = mk({4'h7, 4'hb, 4'hd, 4'he}, {SD, SD, SD, SD}, 1'b1);
    e42  = mk({4'hf, 4'hf, 4'hd, 4'he}, {SX, SX, S4, S2}, 1'b0);

    repeat (2) @(posedge clock_in);
    #1;
    check("rst_anode", 32'(an5), 32'(4'b1110));
    check("rst_seg", 32'(sg5), 32'(S0));
    check("rst_dp", 32'(dp5), 32'd1);
    check("rst_busy", 32'(busy5), 32'd0);
    check("rst_overflow", 32'(ovf5), 32'd0);
    #1 reset_n = 1'b1;
    scan_display(e0, "idle_zero");

    // Single value 27: busy lasts CNT_W+1 cycles.
    sb_q.push_back(e27);
    strobe(27);
    busy_len(n);
    check("busy_len_27", 32'(n), 32'd6);
    wait_sb();

    // 5, then 9 and 12 while busy: 9 is overwritten, two back-to-back conversions.
    sb_q.push_back(e12);
    watch9 = 1'b1;
    @(negedge clock_in);
    cnt5 = 5'd5; valid5 = 1'b1;
    @(negedge clock_in);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 2) begin
        cnt5 = 5'd9;  valid5 = 1'b1;
      end else if (c == 3) begin
        cnt5 = 5'd12; valid5 = 1'b1;
      end else begin
        valid5 = 1'b0;
      end
      if (!busy_m) break;
      n++;
      @(negedge clock_in);
    end
    valid5 = 1'b0;
    check("busy_len_chain", 32'(n), 32'd12);
    wait_sb();
    @(negedge clock_in);
    check("nine_never_shown", 32'(seen9), 32'd0);
    watch9 = 1'b0;

    // Wide instance: overflow then recovery.
    sel = 1'b1;
    sb_q.push_back(eovf);
    strobe(12000);
    wait_sb();
    sb_q.push_back(e42);
    strobe(42);
    wait_sb();
    check("ovf_cleared", 32'(ovf14), 32'd0);
    sel = 1'b0;

    // Blank while showing 27.
    sb_q.push_back(e27);
    strobe(27);
    wait_sb();
    @(negedge clock_in);
    blank = 1'b1;
    @(negedge clock_in);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (an_m !== 4'b1111) n++;
      @(negedge clock_in);
    end
    check("blank_lit_samples", 32'(n), 32'd0);
    blank = 1'b0;
    scan_display(e27, "after_blank");

    // Reset in the middle of converting 31.
    strobe(31);
    repeat (2) @(negedge clock_in);
    @(posedge clock_in);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy5), 32'd0);
    check("mid_rst_anode", 32'(an5), 32'(4'b1110));
    check("mid_rst_seg", 32'(sg5), 32'(S0));
    @(posedge clock_in);
    #2 reset_n = 1'b1;
    scan_display(e0, "after_reset");
    n = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock_in);
      if (busy5) n++;
    end
    check("no_late_commit", 32'(n), 32'd0);
    check("ovf_after_reset", 32'(ovf5), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

endmodule
